mem_controller: RTL and testbench
=================================

// Module: mem_controller
// PURPOSE
// - Single-port memory controller between instruction fetch (IF), data memory stage (MEM) and one async-read RAM.
// - Arbitrates both requesters onto one RAM port; MEM has fixed priority over IF.
// - Muxes the address, generates write enable, owns the bidirectional RAM data bus.
// - Returns registered read data to each requester.
// PARAMETERS
// - DATA_W  32  data width of all data buses
// - ADDR_W  32  byte-address width from IF and MEM
// - RAM_AW  16  RAM word-address width; mc_ram_addr = addr[RAM_AW+1:2]
// PORTS
// - clock        in     1        single clock, all state updates on posedge
// - reset        in     1        synchronous, active-high
// - if_mc_en     in     1        IF read request
// - if_mc_addr   in     ADDR_W   IF byte address
// - mc_if_data   out    DATA_W   registered instruction word to IF
// - mem_mc_rw    in     1        MEM direction: 1 = write, 0 = read
// - mem_mc_en    in     1        MEM request
// - mem_mc_addr  in     ADDR_W   MEM byte address
// - mem_mc_data  inout  DATA_W   MEM data: MEM drives on write, controller drives on read
// - mc_ram_addr  out    RAM_AW   RAM word address
// - mc_ram_wre   out    1        RAM write enable, active-high; RAM output enable = ~mc_ram_wre
// - mc_ram_data  inout  DATA_W   RAM data bus
// BEHAVIOUR
// - Reset (sync, high):
//   - state=IDLE, mc_if_data=0, internal mem_rd_q=0.
//   - mc_ram_wre=0, both inout drivers Z.
// - Arbitration (combinational), each cycle:
//   - mem_mc_en=1: serve MEM.
//   - else if_mc_en=1: serve IF.
//   - else: idle, mc_ram_addr = if_mc_addr word bits.
// - mc_ram_addr = selected addr[RAM_AW+1:2]. Byte offset bits [1:0] are ignored; upper bits are truncated (wrap).
// - mc_ram_wre = mem_mc_en & mem_mc_rw & ~reset.
// - mc_ram_data:
//   - Driven with mem_mc_data while mc_ram_wre=1; else Z.
//   - The RAM drives it during reads.
// - Write: RAM is written at the same posedge the request is sampled. Zero latency, no data returned.
// - Read: RAM data is captured at the posedge the request is sampled.
//   - IF request: captured into mc_if_data.
//   - MEM request: captured into mem_rd_q.
//   - Data is valid the cycle after the request (1-cycle latency). Back-to-back reads give one word per cycle.
// - mem_mc_data is driven with mem_rd_q while state==MEM_RD and mem_mc_en=1 and mem_mc_rw=0; else Z.
// - State machine records the operation performed in the previous cycle:
//   - IDLE / IF_RD / MEM_RD / MEM_WR.
//   - Next state follows the arbitration result of the current cycle.
// - Simultaneous IF and MEM requests:
//   - MEM wins. IF is not served, and mc_if_data holds its previous value.
//   - IF must hold its request until served.
// - Reset mid-access: a write in that cycle is suppressed (wre gated), and the pending read capture is discarded.
// - No X is propagated on the RAM bus: Z is used whenever the controller is not writing.
// CONFIGURATION
// - MC_STALL_EN defined:
//   - Adds output mc_if_stall (1 bit) = if_mc_en & mem_mc_en, combinational, 0 during reset.
//   - IF uses it to freeze its PC.
// - MC_STALL_EN undefined: port absent; the IF pipeline must tolerate the silent hold.
// TESTING
// - Reset then idle: mc_if_data=0, mc_ram_wre=0, mc_ram_data=Z.
// - MEM write addr 0x10, data 0xDEADBEEF -> mc_ram_addr=4, wre=1 one cycle.
//   - Then MEM read 0x10 -> mem_mc_data=0xDEADBEEF next cycle.
// - IF read 0x10 after the above write -> mc_if_data=0xDEADBEEF one cycle later.
// - IF 0x20 and MEM write 0x24 in the same cycle:
//   - MEM served, mc_if_data unchanged.
//   - mc_if_stall=1 when MC_STALL_EN is defined.
//   - Next cycle with IF alone -> word @0x20 returned.
// - Write 0x11111111..0x44444444 to 0x0,0x4,0x8,0xC, then 4 back-to-back IF reads -> data streams in order at 1 word/cycle.
// - Assert reset during a MEM write to 0x8 -> RAM[2] unchanged, outputs reset values.

Source files
------------

// File: rtl/mem_controller_if.sv
// rtl/mem_controller_if.sv - request/response signal bundle between IF, MEM and mem_controller
//
// Purpose: groups the IF fetch port, MEM request port and RAM address/strobe
// outputs of mem_controller. The two bidirectional data buses (mem_mc_data,
// mc_ram_data) are tristate nets and stay plain inout ports on the controller.
//
// Signals:
//   if_mc_en     IF read request
//   if_mc_addr   IF byte address
//   mc_if_data   registered instruction word to IF
//   mem_mc_rw    MEM direction: 1 = write, 0 = read
//   mem_mc_en    MEM request
//   mem_mc_addr  MEM byte address
//   mc_ram_addr  RAM word address
//   mc_ram_wre   RAM write enable (active-high), RAM output enable = ~mc_ram_wre
//
// Modports: master = requester side (IF/MEM), slave = controller side.

interface mem_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 16
);
    logic              if_mc_en;
    logic [ADDR_W-1:0] if_mc_addr;
    logic [DATA_W-1:0] mc_if_data;
    logic              mem_mc_rw;
    logic              mem_mc_en;
    logic [ADDR_W-1:0] mem_mc_addr;
    logic [RAM_AW-1:0] mc_ram_addr;
    logic              mc_ram_wre;

    modport master (
        output if_mc_en, if_mc_addr, mem_mc_rw, mem_mc_en, mem_mc_addr,
        input  mc_if_data, mc_ram_addr, mc_ram_wre
    );

    modport slave (
        input  if_mc_en, if_mc_addr, mem_mc_rw, mem_mc_en, mem_mc_addr,
        output mc_if_data, mc_ram_addr, mc_ram_wre
    );
endinterface

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - single-port RAM controller arbitrating IF and MEM (MEM priority)
//
// Purpose: muxes IF and MEM requests onto one async-read RAM port. MEM has
// fixed priority; a blocked IF request is simply not served and must be held.
// Writes complete at the posedge the request is sampled; reads are captured at
// that posedge and returned one cycle later (mc_if_data / mem_mc_data).
//
// Ports:
//   clock        in     single clock, all state updates on posedge
//   reset        in     synchronous, active-high
//   bus          slave  mem_controller_if (IF/MEM requests, mc_if_data, RAM addr/wre)
//   mem_mc_data  inout  MEM data: MEM drives on write, controller drives on read
//   mc_ram_data  inout  RAM data: controller drives on write, RAM drives on read
//   mc_if_stall  out    (MC_STALL_EN only) IF blocked by MEM this cycle
//
// Configuration macro: MC_STALL_EN adds the mc_if_stall output.

module mem_controller #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 16
) (
    input  logic                clock,
    input  logic                reset,
    mem_controller_if.slave     bus,
    inout  wire  [DATA_W-1:0]   mem_mc_data,
    inout  wire  [DATA_W-1:0]   mc_ram_data
`ifdef MC_STALL_EN
    ,
    output logic                mc_if_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_rd;

    logic              w_sel_mem;
    logic              w_sel_if;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wre;
    logic              w_mem_drive;
    logic              w_unused_addr_bits;

    // MEM wins whenever it requests; IF only gets the port when MEM is quiet.
    assign w_sel_mem = bus.mem_mc_en;
    assign w_sel_if  = ~bus.mem_mc_en & bus.if_mc_en;

    // Idle cycles still present the IF address so the RAM output is defined.
    assign w_addr = w_sel_mem ? bus.mem_mc_addr : bus.if_mc_addr;

    // Byte offset is dropped and high bits truncated, so addresses wrap.
    assign bus.mc_ram_addr = w_addr[RAM_AW+1:2];
    assign w_unused_addr_bits = &{1'b0, w_addr[ADDR_W-1:RAM_AW+2], w_addr[1:0]};

    // Gated by reset so a write issued in the reset cycle never lands.
    assign w_wre          = bus.mem_mc_en & bus.mem_mc_rw & ~reset;
    assign bus.mc_ram_wre = w_wre;

    assign mc_ram_data = w_wre ? mem_mc_data : {DATA_W{1'bz}};

    // Read data is returned only while MEM keeps a read request up in the
    // cycle after the capture.
    assign w_mem_drive = (r_state == MEM_RD) & bus.mem_mc_en & ~bus.mem_mc_rw & ~reset;
    assign mem_mc_data = w_mem_drive ? r_mem_rd : {DATA_W{1'bz}};

    assign bus.mc_if_data = r_if_data;

`ifdef MC_STALL_EN
    assign mc_if_stall = bus.if_mc_en & bus.mem_mc_en & ~reset;
`endif

    // State records the operation performed this cycle; read captures happen
    // at the same edge, so data is visible one cycle after the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_if_data <= '0;
            r_mem_rd  <= '0;
        end else begin
            if (w_sel_mem) begin
                if (bus.mem_mc_rw) begin
                    r_state <= MEM_WR;
                end else begin
                    r_state  <= MEM_RD;
                    r_mem_rd <= mc_ram_data;
                end
            end else if (w_sel_if) begin
                r_state   <= IF_RD;
                r_if_data <= mc_ram_data;
            end else begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed table-driven bench for mem_controller

module tb_mem_controller;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int RAM_AW = 16;

    logic clock;
    logic reset;

    wire [DATA_W-1:0] mem_mc_data;
    wire [DATA_W-1:0] mc_ram_data;

    logic              tb_mem_drive;
    logic [DATA_W-1:0] tb_mem_wdata;

    logic [DATA_W-1:0] ram [0:(1<<RAM_AW)-1];

`ifdef MC_STALL_EN
    logic mc_if_stall;
`endif

    mem_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) bus ();

    mem_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .mem_mc_data (mem_mc_data),
        .mc_ram_data (mc_ram_data)
`ifdef MC_STALL_EN
        ,
        .mc_if_stall (mc_if_stall)
`endif
    );

    // MEM-side write data source and async-read RAM model.
    assign mem_mc_data = tb_mem_drive ? tb_mem_wdata : {DATA_W{1'bz}};
    assign mc_ram_data = bus.mc_ram_wre ? {DATA_W{1'bz}} : ram[bus.mc_ram_addr];

    always @(posedge clock) begin
        if (bus.mc_ram_wre) ram[bus.mc_ram_addr] <= mc_ram_data;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        if_en;
        logic [31:0] if_addr;
        logic        mem_en;
        logic        mem_rw;
        logic [31:0] mem_addr;
        logic [31:0] wdata;
        logic [15:0] exp_ram_addr;
        logic        exp_wre;
        logic        chk_mem;
        logic [31:0] exp_mem;
        logic [31:0] exp_if;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int checks;
    int failures;

    task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
        end
    endtask

    task automatic drive(input logic if_en, input logic [31:0] if_addr, input logic mem_en,
                         input logic mem_rw, input logic [31:0] mem_addr, input logic [31:0] wdata);
        bus.if_mc_en    = if_en;
        bus.if_mc_addr  = if_addr;
        bus.mem_mc_en   = mem_en;
        bus.mem_mc_rw   = mem_rw;
        bus.mem_mc_addr = mem_addr;
        tb_mem_wdata    = wdata;
        tb_mem_drive    = mem_en & mem_rw;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          if  if_addr        mem mrw mem_addr       wdata         raddr    wre chk exp_mem        exp_if
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0000, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h10,        32'hDEADBEEF, 16'h0004, 1'b1, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h10,        32'h0,         16'h0004, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h10,        32'h0,         16'h0004, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0004, 1'b0, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0,         32'h11111111, 16'h0000, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[6]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h4,         32'h22222222, 16'h0001, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h8,         32'h33333333, 16'h0002, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'hC,         32'h44444444, 16'h0003, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h20,        32'h55555555, 16'h0008, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[10] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0000, 1'b0, 1'b0, 32'h0,         32'h11111111};
        vecs[11] = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0001, 1'b0, 1'b0, 32'h0,         32'h22222222};
        vecs[12] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0002, 1'b0, 1'b0, 32'h0,         32'h33333333};
        vecs[13] = '{1'b1, 32'h0000_000C, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0003, 1'b0, 1'b0, 32'h0,         32'h44444444};
        vecs[14] = '{1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h24,        32'hAAAAAAAA, 16'h0009, 1'b1, 1'b0, 32'h0,         32'h44444444};
        vecs[15] = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0008, 1'b0, 1'b0, 32'h0,         32'h55555555};
        vecs[16] = '{1'b1, 32'h0004_0013, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0004, 1'b0, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[17] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h24,        32'h0,         16'h0009, 1'b0, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[18] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h8,         32'h0,         16'h0002, 1'b0, 1'b1, 32'hAAAAAAAA, 32'hDEADBEEF};
        vecs[19] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         32'h0,         16'h0000, 1'b0, 1'b1, 32'h33333333, 32'hDEADBEEF};
        vecs[20] = '{1'b0, 32'h0000_0014, 1'b0, 1'b0, 32'h0,         32'h0,         16'h0005, 1'b0, 1'b0, 32'h0,         32'hDEADBEEF};

        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = '0;

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_if_data", -1, bus.mc_if_data, 32'h0);
        check("reset_wre", -1, {31'h0, bus.mc_ram_wre}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].if_en, vecs[i].if_addr, vecs[i].mem_en, vecs[i].mem_rw,
                  vecs[i].mem_addr, vecs[i].wdata);
            #1;
            check("ram_addr", i, {16'h0, bus.mc_ram_addr}, {16'h0, vecs[i].exp_ram_addr});
            check("ram_wre", i, {31'h0, bus.mc_ram_wre}, {31'h0, vecs[i].exp_wre});
            if (vecs[i].chk_mem) check("mem_rdata", i, mem_mc_data, vecs[i].exp_mem);
`ifdef MC_STALL_EN
            check("if_stall", i, {31'h0, mc_if_stall}, {31'h0, vecs[i].if_en & vecs[i].mem_en});
`endif
            @(posedge clock);
            #1;
            check("if_data", i, bus.mc_if_data, vecs[i].exp_if);
        end

        // Reset asserted during a MEM write to 0x8: write suppressed, outputs cleared.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h99999999);
        reset = 1'b1;
        #1;
        check("rst_wr_wre", 100, {31'h0, bus.mc_ram_wre}, 32'h0);
        @(posedge clock);
        #1;
        check("rst_wr_if_data", 100, bus.mc_if_data, 32'h0);
        check("rst_wr_ram2", 100, ram[2], 32'h33333333);
        reset = 1'b0;
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rst_rd_addr", 101, {16'h0, bus.mc_ram_addr}, 32'h2);
        @(posedge clock);
        #1;
        check("rst_rd_if_data", 101, bus.mc_if_data, 32'h33333333);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
